ws2811_frame_sequencer: RTL and testbench

Parametrised frame scheduler that streams a rotating pattern from a pattern ROM to a WS2811 serial transmitter.
- Each frame tick sends UNITS_NUMBER pixels, then enforces the WS2811 latch gap before another frame may start.
- Adds selectable shift direction and step, per-pixel brightness scaling, non-power-of-two pattern wrap, enable gating and overrun reporting.
- Sits between the top level, the pattern ROM (1-cycle read latency) and the transmitter.

---
 rtl/ws2811_pkg.sv | 13 +
 rtl/ws2811_pixel_scaler.sv | 14 +
 rtl/ws2811_frame_sequencer.sv | 111 +++++++++++
 tb/tb_ws2811_frame_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// ws2811_pkg: shared types, constants and channel scaling for the WS2811 frame sequencer
package ws2811_pkg;
  localparam int WS2811_LATCH_US = 50;
  typedef enum logic [2:0] {IDLE, FETCH, ROMWAIT, SEND, ACK, DONE, LATCH} state_t;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] k);
    return 8'((16'(c) * (16'(k) + 16'd1)) >> 8);
  endfunction
endpackage

// File: rtl/ws2811_pixel_scaler.sv
// ws2811_pixel_scaler: applies global brightness to all three GRB channels
module ws2811_pixel_scaler
  import ws2811_pkg::*;
(
  input  pixel_t     i_pixel,
  input  logic [7:0] i_brightness,
  output pixel_t     o_pixel
);
  always_comb begin
    o_pixel.g = scale8(i_pixel.g, i_brightness);
    o_pixel.r = scale8(i_pixel.r, i_brightness);
    o_pixel.b = scale8(i_pixel.b, i_brightness);
  end
endmodule

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer: ticks frames of rotating ROM pixels out to a WS2811 transmitter
module ws2811_frame_sequencer
  import ws2811_pkg::*;
#(
  parameter int UNITS_NUMBER          = 100,
  parameter int PATTERN_PIXELS_NUMBER = 128,
  parameter int CLOCK_SPEED           = 50_000_000,
  parameter int UPDATES_PER_SECOND    = 20,
  parameter int LATCH_CYCLES          = CLOCK_SPEED / 1_000_000 * WS2811_LATCH_US,
  parameter int ADDR_W                = $clog2(PATTERN_PIXELS_NUMBER)
) (
  input  logic              clkIN,
  input  logic              nResetIN,
  input  logic              enableIN,
  input  logic              directionIN,
  input  logic [7:0]        stepIN,
  input  logic [7:0]        brightnessIN,
  output logic [ADDR_W-1:0] romAddressOUT,
  input  logic [23:0]       romDataIN,
  output logic              txStartOUT,
  output logic [23:0]       txDataOUT,
  input  logic              txBusyIN,
  output logic              busyOUT,
  output logic              frameDoneOUT,
  output logic              overrunOUT
);
  localparam int TICK_CYCLES = CLOCK_SPEED / UPDATES_PER_SECOND;
  localparam int N  = PATTERN_PIXELS_NUMBER;
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int IW = $clog2(UNITS_NUMBER + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  state_t            r_state;
  logic [TW-1:0]     r_tick;
  logic [IW-1:0]     r_index;
  logic [LW-1:0]     r_latch;
  logic [ADDR_W-1:0] r_base;
  logic              w_tick;
  logic [31:0]       w_step, w_fwd, w_back;
  logic [ADDR_W-1:0] w_next_base, w_next_addr;
  pixel_t            w_scaled;
  ws2811_pixel_scaler u_scaler (
    .i_pixel      (romDataIN),
    .i_brightness (brightnessIN),
    .o_pixel      (w_scaled)
  );
  // both wraps use compare-and-subtract so any pattern depth works
  always_comb begin
    w_tick      = 32'(r_tick) == TICK_CYCLES - 1;
    w_step      = 32'(stepIN) % N;
    w_fwd       = 32'(r_base) + w_step;
    w_back      = 32'(r_base) + N - w_step;
    w_next_base = ADDR_W'(directionIN ? (w_back >= N ? w_back - N : w_back)
                                      : (w_fwd >= N ? w_fwd - N : w_fwd));
    w_next_addr = 32'(romAddressOUT) == N - 1 ? '0 : romAddressOUT + 1'b1;
  end
  always_ff @(posedge clkIN) begin
    if (!nResetIN) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_index       <= '0;
      r_latch       <= '0;
      r_base        <= '0;
      romAddressOUT <= '0;
      txStartOUT    <= 1'b0;
      txDataOUT     <= '0;
      busyOUT       <= 1'b0;
      frameDoneOUT  <= 1'b0;
      overrunOUT    <= 1'b0;
    end else begin
      r_tick       <= w_tick ? '0 : r_tick + 1'b1;
      txStartOUT   <= 1'b0;
      frameDoneOUT <= 1'b0;
      overrunOUT   <= w_tick && busyOUT;
      case (r_state)
        IDLE: if (w_tick && enableIN) begin
          r_index       <= '0;
          busyOUT       <= 1'b1;
          romAddressOUT <= r_base;
          r_state       <= FETCH;
        end
        FETCH: r_state <= ROMWAIT;
        ROMWAIT: begin
          txDataOUT <= w_scaled;
          r_state   <= SEND;
        end
        SEND: if (!txBusyIN) begin
          txStartOUT <= 1'b1;
          r_state    <= ACK;
        end
        ACK: if (txBusyIN) r_state <= DONE;
        DONE: if (!txBusyIN) begin
          r_index <= r_index + 1'b1;
          if (32'(r_index) == UNITS_NUMBER - 1) begin
            r_latch <= '0;
            r_state <= LATCH;
          end else begin
            romAddressOUT <= w_next_addr;
            r_state       <= FETCH;
          end
        end
        LATCH: if (32'(r_latch) == LATCH_CYCLES - 1) begin
          frameDoneOUT <= 1'b1;
          busyOUT      <= 1'b0;
          r_base       <= w_next_base;
          r_state      <= IDLE;
        end else r_latch <= r_latch + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// tb_ws2811_frame_sequencer: transaction-level model check plus directed literal expectations
module tb_ws2811_frame_sequencer;
  localparam int UNITS = 4, N = 5, TICK = 200, LATCH = 10;
  logic clk = 0, nrst = 0, en = 0, dir = 0;
  logic [7:0] step = 8'd1, bright = 8'd255;
  logic [2:0] addr;
  logic [23:0] romd = '0, txd;
  logic txs, txb, busy, done, ovr;
  logic [23:0] rom [N];
  int hold = 8, tcnt = 0;
  int passed = 0, total = 0, frames = 0, starts = 0, ovr_cnt = 0;
  int m_t = 0, m_sent = 0, m_low = 0, m_base = 0;
  logic m_seen = 0, e_busy = 0, e_done = 0, e_ovr = 0, prev_txb = 0, chk_en = 0;
  int addr_q[$];
  logic [23:0] txlog[$];
  int exp6 [24] = '{0,1,2,3, 1,2,3,4, 2,3,4,0, 3,4,0,1, 1,2,3,4, 3,4,0,1};

  ws2811_frame_sequencer #(
    .UNITS_NUMBER(UNITS), .PATTERN_PIXELS_NUMBER(N), .CLOCK_SPEED(4000),
    .UPDATES_PER_SECOND(20), .LATCH_CYCLES(LATCH)
  ) dut (
    .clkIN(clk), .nResetIN(nrst), .enableIN(en), .directionIN(dir), .stepIN(step),
    .brightnessIN(bright), .romAddressOUT(addr), .romDataIN(romd), .txStartOUT(txs),
    .txDataOUT(txd), .txBusyIN(txb), .busyOUT(busy), .frameDoneOUT(done), .overrunOUT(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) romd <= rom[addr];
  always @(posedge clk) tcnt <= txs ? hold : (tcnt > 0 ? tcnt - 1 : 0);
  assign txb = tcnt != 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [23:0] scale(input logic [23:0] p, input int b);
    int g, r, bl;
    g  = int'(p[23:16]) * (b + 1) / 256;
    r  = int'(p[15:8]) * (b + 1) / 256;
    bl = int'(p[7:0]) * (b + 1) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  always @(negedge clk) begin : model
    logic tick;
    if (chk_en) begin
      chk("busyOUT", 32'(busy), 32'(e_busy));
      chk("frameDoneOUT", 32'(done), 32'(e_done));
      chk("overrunOUT", 32'(ovr), 32'(e_ovr));
      if (txs) begin
        chk("start_tx_idle", 32'(prev_txb), 0);
        chk("start_in_frame", 32'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) chk("txDataOUT", 32'(txd), 32'(scale(rom[addr_q.pop_front()], int'(bright))));
        txlog.push_back(txd);
        m_sent++;
        starts++;
      end
    end
    if (done) frames++;
    if (ovr) ovr_cnt++;
    if (!nrst) begin
      m_t = 0; m_sent = 0; m_low = 0; m_base = 0; m_seen = 0;
      e_busy = 0; e_done = 0; e_ovr = 0;
      addr_q.delete();
    end else begin
      tick = m_t == TICK - 1;
      e_ovr = tick && e_busy;
      e_done = 0;
      if (e_busy && m_sent == UNITS) begin
        if (txb) m_seen = 1;
        else if (m_seen) m_low++;
        if (m_low == LATCH + 1) begin
          e_done = 1; e_busy = 0; m_sent = 0; m_seen = 0; m_low = 0;
          m_base = dir ? (m_base + N - int'(step) % N) % N : (m_base + int'(step)) % N;
        end
      end else if (!e_busy && tick && en) begin
        e_busy = 1;
        for (int j = 0; j < UNITS; j++) addr_q.push_back((m_base + j) % N);
      end
      m_t = tick ? 0 : m_t + 1;
    end
    prev_txb = txb;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames < n; i++) @(negedge clk);
    chk("frames_reached", frames, n);
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && starts < n; i++) @(negedge clk);
    chk("starts_reached", starts, n);
  endtask

  initial begin
    int ov0, st0, lg;
    for (int i = 0; i < N; i++) rom[i] = 24'(i);
    repeat (3) cyc();
    chk_en = 1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txStart", 32'(txs), 0);
    chk("rst_txData", 32'(txd), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovr", 32'(ovr), 0);
    nrst = 1;
    en = 1;
    wait_frames(3, 1000);
    cyc(); dir = 1; step = 8'd2;
    wait_frames(4, 400);
    cyc(); step = 8'd3;
    wait_frames(5, 400);
    wait_frames(6, 400);
    chk("log_size_6", txlog.size(), 24);
    for (int i = 0; i < 24; i++) chk("frame_seq", 32'(txlog[i]), exp6[i]);
    cyc(); dir = 0; step = 8'd0;
    for (int i = 0; i < N; i++) rom[i] = 24'hFF8001;
    wait_frames(7, 400);
    chk("bright255_first", 32'(txlog[24]), 32'hFF8001);
    chk("bright255_last", 32'(txlog[27]), 32'hFF8001);
    cyc(); bright = 8'd127;
    wait_frames(8, 400);
    chk("bright127", 32'(txlog[28]), 32'h7F4000);
    cyc(); bright = 8'd0;
    wait_frames(9, 400);
    chk("bright0", 32'(txlog[32]), 0);
    cyc(); bright = 8'd255; step = 8'd1; hold = 150;
    for (int i = 0; i < N; i++) rom[i] = 24'(i);
    ov0 = ovr_cnt;
    wait_frames(10, 800);
    chk("overrun_count", ovr_cnt - ov0, 3);
    chk("long_frame_pix3", 32'(txlog[39]), 3);
    cyc(); hold = 8;
    wait_frames(11, 400);
    chk("after_overrun_base", 32'(txlog[40]), 1);
    chk("no_queued_frame", ovr_cnt - ov0, 3);
    st0 = starts;
    wait_starts(st0 + 2, 400);
    repeat (3) cyc();
    nrst = 0;
    cyc();
    nrst = 1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_txStart", 32'(txs), 0);
    chk("mid_rst_txData", 32'(txd), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    lg = txlog.size();
    wait_starts(st0 + 3, 400);
    cyc(); en = 0;
    wait_frames(12, 400);
    for (int j = 0; j < UNITS; j++) chk("post_rst_seq", 32'(txlog[lg + j]), j);
    ov0 = ovr_cnt;
    st0 = starts;
    repeat (500) cyc();
    chk("disabled_no_start", starts, st0);
    chk("disabled_no_ovr", ovr_cnt, ov0);
    chk("disabled_no_frame", frames, 12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
